id_ex_stage: RTL and testbench

- ID/EX pipeline register and operand-forwarding stage directly upstream of the 32-bit ALU in the 5-stage pipeline.
- Captures decoded instructions, detects load-use hazards, and inserts bubbles.
- Resolves EX/MEM and MEM/WB forwarding so the ALU receives final a, b and aluop operands.
- Honours a downstream hold and a branch flush.

---
 rtl/id_ex_stage_pkg.sv | 36 +++
 rtl/id_ex_stage_fwd_mux.sv | 25 ++
 rtl/id_ex_stage.sv | 120 ++++++++++++
 tb/tb_id_ex_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline constants, ALU opcodes and the ID/EX bundle used by the
// ID/EX register and its forwarding selectors.
package id_ex_stage_pkg;

  localparam int XLEN = 32;
  localparam int RW   = 5;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  typedef struct packed {
    logic            valid;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic [3:0]      aluop;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
  } idex_t;

  // A producer only forwards if it writes a register other than x0.
  function automatic logic fwd_hit(input logic we, input logic [RW-1:0] rd,
                                   input logic [RW-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Forwarding selector for one ALU source operand; EX/MEM beats MEM/WB.
module fwd_mux
  import id_ex_stage_pkg::*;
(
  input  logic [RW-1:0]   rs,
  input  logic [XLEN-1:0] rdata,
  input  logic [RW-1:0]   exmem_rd,
  input  logic            exmem_regwrite,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [RW-1:0]   memwb_rd,
  input  logic            memwb_regwrite,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] value
);

  always_comb begin
    value = rdata;
    if (fwd_hit(exmem_regwrite, exmem_rd, rs)) begin
      value = exmem_result;
    end else if (fwd_hit(memwb_regwrite, memwb_rd, rs)) begin
      value = memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, hold/flush handling
// and operand forwarding feeding the ALU.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [RW-1:0]   id_rs1,
  input  logic [RW-1:0]   id_rs2,
  input  logic [RW-1:0]   id_rd,
  input  logic [XLEN-1:0] id_rdata1,
  input  logic [XLEN-1:0] id_rdata2,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_use_imm,
  input  logic [3:0]      id_aluop,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            id_memwrite,
  input  logic            flush,
  input  logic            hold,
  input  logic [RW-1:0]   exmem_rd,
  input  logic            exmem_regwrite,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [RW-1:0]   memwb_rd,
  input  logic            memwb_regwrite,
  input  logic [XLEN-1:0] memwb_result,
  output logic            id_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [3:0]      ex_aluop,
  output logic [RW-1:0]   ex_rd,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic [XLEN-1:0] ex_store_data
);

  idex_t           ex_q;
  idex_t           id_bundle;
  logic            load_use;
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;

  assign id_bundle = '{valid: id_valid, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                       rdata1: id_rdata1, rdata2: id_rdata2, imm: id_imm,
                       use_imm: id_use_imm, aluop: id_aluop,
                       regwrite: id_regwrite, memread: id_memread,
                       memwrite: id_memwrite};

  // A load in EX cannot feed the very next instruction; rs2 only matters
  // when operand b actually comes from the register file.
  always_comb begin
    load_use = 1'b0;
    if (ex_q.valid && ex_q.memread && (ex_q.rd != '0) && id_valid) begin
      load_use = (ex_q.rd == id_rs1) || (!id_use_imm && (ex_q.rd == id_rs2));
    end
  end

  assign id_stall = load_use || hold;

  // While held, operands are re-latched post-forwarding so a producer that
  // retires from MEM/WB during the hold does not take its value with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
    end else if (flush) begin
      ex_q.valid    <= 1'b0;
      ex_q.regwrite <= 1'b0;
      ex_q.memread  <= 1'b0;
      ex_q.memwrite <= 1'b0;
    end else if (hold) begin
      ex_q.rdata1 <= fwd_a;
      ex_q.rdata2 <= fwd_b;
    end else if (load_use) begin
      ex_q.valid    <= 1'b0;
      ex_q.regwrite <= 1'b0;
      ex_q.memread  <= 1'b0;
      ex_q.memwrite <= 1'b0;
    end else begin
      ex_q <= id_bundle;
    end
  end

  fwd_mux u_fwd_a (
    .rs             (ex_q.rs1),
    .rdata          (ex_q.rdata1),
    .exmem_rd       (exmem_rd),
    .exmem_regwrite (exmem_regwrite),
    .exmem_result   (exmem_result),
    .memwb_rd       (memwb_rd),
    .memwb_regwrite (memwb_regwrite),
    .memwb_result   (memwb_result),
    .value          (fwd_a)
  );

  fwd_mux u_fwd_b (
    .rs             (ex_q.rs2),
    .rdata          (ex_q.rdata2),
    .exmem_rd       (exmem_rd),
    .exmem_regwrite (exmem_regwrite),
    .exmem_result   (exmem_result),
    .memwb_rd       (memwb_rd),
    .memwb_regwrite (memwb_regwrite),
    .memwb_result   (memwb_result),
    .value          (fwd_b)
  );

  assign ex_valid      = ex_q.valid;
  assign ex_a          = fwd_a;
  assign ex_b          = ex_q.use_imm ? ex_q.imm : fwd_b;
  assign ex_store_data = fwd_b;
  assign ex_aluop      = ex_q.aluop;
  assign ex_rd         = ex_q.rd;
  assign ex_regwrite   = ex_q.regwrite;
  assign ex_memread    = ex_q.memread;
  assign ex_memwrite   = ex_q.memwrite;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors push expectations, a
// monitor samples the outputs mid-cycle and compares.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  typedef struct packed {
    logic        rst, flush, hold, valid;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rdata1, rdata2, imm;
    logic        use_imm;
    logic [3:0]  aluop;
    logic        regwrite, memread, memwrite;
    logic [4:0]  exmem_rd;
    logic        exmem_regwrite;
    logic [31:0] exmem_result;
    logic [4:0]  memwb_rd;
    logic        memwb_regwrite;
    logic [31:0] memwb_result;
  } stim_t;

  typedef struct {
    string       name;
    logic        stall, valid, regwrite, memread, memwrite;
    logic [3:0]  aluop;
    logic [31:0] a, b, st;
    bit          chk_a, chk_b, chk_st, chk_op;
  } exp_t;

  logic clk, rst;
  logic id_valid, id_use_imm, id_regwrite, id_memread, id_memwrite;
  logic [4:0] id_rs1, id_rs2, id_rd, exmem_rd, memwb_rd, ex_rd;
  logic [31:0] id_rdata1, id_rdata2, id_imm, exmem_result, memwb_result;
  logic [3:0] id_aluop, ex_aluop;
  logic flush, hold, exmem_regwrite, memwb_regwrite;
  logic id_stall, ex_valid, ex_regwrite, ex_memread, ex_memwrite;
  logic [31:0] ex_a, ex_b, ex_store_data;

  exp_t expq[$];
  int vectors = 0;
  int miscompares = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_aluop(id_aluop), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .flush(flush), .hold(hold),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .memwb_result(memwb_result),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
    .ex_aluop(ex_aluop), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_store_data(ex_store_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t noop();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t instr(input logic [4:0] rs1, input logic [31:0] rdata1,
                                  input logic [4:0] rs2, input logic [31:0] rdata2,
                                  input logic use_imm, input logic [31:0] imm,
                                  input logic [3:0] aluop, input logic [4:0] rd,
                                  input logic regwrite, input logic memread,
                                  input logic memwrite);
    stim_t s;
    s = '0;
    s.valid = 1'b1; s.rs1 = rs1; s.rdata1 = rdata1; s.rs2 = rs2; s.rdata2 = rdata2;
    s.use_imm = use_imm; s.imm = imm; s.aluop = aluop; s.rd = rd;
    s.regwrite = regwrite; s.memread = memread; s.memwrite = memwrite;
    return s;
  endfunction

  function automatic exp_t ctl(input string name, input logic stall, input logic valid,
                               input logic regwrite, input logic memread,
                               input logic memwrite);
    exp_t e;
    e.name = name; e.stall = stall; e.valid = valid; e.regwrite = regwrite;
    e.memread = memread; e.memwrite = memwrite;
    e.aluop = '0; e.a = '0; e.b = '0; e.st = '0;
    e.chk_a = 1'b0; e.chk_b = 1'b0; e.chk_st = 1'b0; e.chk_op = 1'b0;
    return e;
  endfunction

  task automatic applyStimulus(input stim_t s, input exp_t e);
    @(negedge clk);
    #1;
    rst = s.rst; flush = s.flush; hold = s.hold;
    id_valid = s.valid; id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd;
    id_rdata1 = s.rdata1; id_rdata2 = s.rdata2; id_imm = s.imm;
    id_use_imm = s.use_imm; id_aluop = s.aluop; id_regwrite = s.regwrite;
    id_memread = s.memread; id_memwrite = s.memwrite;
    exmem_rd = s.exmem_rd; exmem_regwrite = s.exmem_regwrite; exmem_result = s.exmem_result;
    memwb_rd = s.memwb_rd; memwb_regwrite = s.memwb_regwrite; memwb_result = s.memwb_result;
    expq.push_back(e);
  endtask

  task automatic cmp(input string tag, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp({e.name, ".id_stall"}, {31'd0, id_stall}, {31'd0, e.stall});
    cmp({e.name, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, e.valid});
    cmp({e.name, ".ex_regwrite"}, {31'd0, ex_regwrite}, {31'd0, e.regwrite});
    cmp({e.name, ".ex_memread"}, {31'd0, ex_memread}, {31'd0, e.memread});
    cmp({e.name, ".ex_memwrite"}, {31'd0, ex_memwrite}, {31'd0, e.memwrite});
    if (e.chk_a) cmp({e.name, ".ex_a"}, ex_a, e.a);
    if (e.chk_b) cmp({e.name, ".ex_b"}, ex_b, e.b);
    if (e.chk_st) cmp({e.name, ".ex_store_data"}, ex_store_data, e.st);
    if (e.chk_op) cmp({e.name, ".ex_aluop"}, {28'd0, ex_aluop}, {28'd0, e.aluop});
  endtask

  // Monitor: sample two time units after the stimulus settles each cycle.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (expq.size() > 0) checkOutput(expq.pop_front());
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    exp_t e;
    rst = 1'b1; flush = 1'b0; hold = 1'b0;
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rdata1 = '0; id_rdata2 = '0; id_imm = '0; id_use_imm = 1'b0; id_aluop = '0;
    id_regwrite = 1'b0; id_memread = 1'b0; id_memwrite = 1'b0;
    exmem_rd = '0; exmem_regwrite = 1'b0; exmem_result = '0;
    memwb_rd = '0; memwb_regwrite = 1'b0; memwb_result = '0;

    s = noop(); s.rst = 1'b1;
    e = ctl("reset", 0, 0, 0, 0, 0);
    e.chk_a = 1; e.chk_b = 1; e.chk_st = 1; e.chk_op = 1;
    applyStimulus(s, e);

    s = instr(1, 32'd5, 2, 32'd7, 0, 0, ALU_ADD, 3, 1, 0, 0);
    applyStimulus(s, ctl("adv_pre", 0, 0, 0, 0, 0));

    s = instr(4, 32'h44, 0, 0, 1, 32'h100, ALU_SUB, 5, 1, 0, 0);
    e = ctl("advance", 0, 1, 1, 0, 0);
    e.chk_a = 1; e.a = 32'd5; e.chk_b = 1; e.b = 32'd7; e.chk_st = 1; e.st = 32'd7;
    e.chk_op = 1; e.aluop = ALU_ADD;
    applyStimulus(s, e);

    s.exmem_rd = 4; s.exmem_regwrite = 1; s.exmem_result = 32'h11;
    s.memwb_rd = 4; s.memwb_regwrite = 1; s.memwb_result = 32'h22;
    e = ctl("fwd_both", 0, 1, 1, 0, 0);
    e.chk_a = 1; e.a = 32'h11; e.chk_b = 1; e.b = 32'h100; e.chk_op = 1; e.aluop = ALU_SUB;
    applyStimulus(s, e);

    s.exmem_regwrite = 0;
    e = ctl("fwd_memwb", 0, 1, 1, 0, 0);
    e.chk_a = 1; e.a = 32'h22;
    applyStimulus(s, e);

    s = instr(0, 32'h0, 0, 0, 1, 32'd3, ALU_OR, 7, 1, 0, 0);
    e = ctl("fwd_none", 0, 1, 1, 0, 0);
    e.chk_a = 1; e.a = 32'h44; e.chk_b = 1; e.b = 32'h100;
    applyStimulus(s, e);

    s = instr(1, 32'h1000, 0, 0, 1, 32'd4, ALU_ADD, 6, 1, 1, 0);
    s.exmem_rd = 0; s.exmem_regwrite = 1; s.exmem_result = 32'hFF;
    s.memwb_rd = 0; s.memwb_regwrite = 1; s.memwb_result = 32'hEE;
    e = ctl("x0_nofwd", 0, 1, 1, 0, 0);
    e.chk_a = 1; e.a = 32'h0; e.chk_b = 1; e.b = 32'd3; e.chk_op = 1; e.aluop = ALU_OR;
    applyStimulus(s, e);

    s = instr(2, 32'h20, 6, 32'h60, 0, 0, ALU_ADD, 8, 1, 0, 0);
    e = ctl("load_use", 1, 1, 1, 1, 0);
    e.chk_a = 1; e.a = 32'h1000; e.chk_b = 1; e.b = 32'd4;
    applyStimulus(s, e);

    applyStimulus(s, ctl("bubble", 0, 0, 0, 0, 0));

    s = instr(9, 32'h0, 0, 0, 1, 32'd1, ALU_ADD, 10, 1, 0, 0);
    s.memwb_rd = 6; s.memwb_regwrite = 1; s.memwb_result = 32'h6666;
    e = ctl("dep_issue", 0, 1, 1, 0, 0);
    e.chk_a = 1; e.a = 32'h20; e.chk_b = 1; e.b = 32'h6666; e.chk_st = 1; e.st = 32'h6666;
    e.chk_op = 1; e.aluop = ALU_ADD;
    applyStimulus(s, e);

    s = instr(1, 32'h77, 0, 0, 1, 32'd2, ALU_SUB, 11, 1, 0, 0);
    s.hold = 1; s.memwb_rd = 9; s.memwb_regwrite = 1; s.memwb_result = 32'hABCD;
    e = ctl("hold_fwd", 1, 1, 1, 0, 0);
    e.chk_a = 1; e.a = 32'hABCD; e.chk_b = 1; e.b = 32'd1;
    applyStimulus(s, e);

    s.memwb_rd = 12; s.memwb_result = 32'h5555;
    e = ctl("hold_retire", 1, 1, 1, 0, 0);
    e.chk_a = 1; e.a = 32'hABCD;
    applyStimulus(s, e);

    s.hold = 0; s.memwb_rd = 0; s.memwb_regwrite = 0; s.memwb_result = 0;
    e = ctl("hold_release", 0, 1, 1, 0, 0);
    e.chk_a = 1; e.a = 32'hABCD; e.chk_b = 1; e.b = 32'd1;
    applyStimulus(s, e);

    s = instr(3, 32'h33, 0, 0, 1, 32'd0, ALU_MUL, 4, 1, 0, 0);
    s.flush = 1; s.hold = 1;
    e = ctl("flush_hold_pre", 1, 1, 1, 0, 0);
    e.chk_a = 1; e.a = 32'h77; e.chk_b = 1; e.b = 32'd2; e.chk_op = 1; e.aluop = ALU_SUB;
    applyStimulus(s, e);

    s = instr(5, 32'd5, 0, 0, 1, 32'd8, ALU_AND, 0, 0, 0, 1);
    applyStimulus(s, ctl("flushed", 0, 0, 0, 0, 0));

    s = instr(1, 32'd9, 0, 0, 1, 32'd0, ALU_OR, 14, 1, 0, 0);
    e = ctl("memwrite_cap", 0, 1, 0, 0, 1);
    e.chk_a = 1; e.a = 32'd5; e.chk_b = 1; e.b = 32'd8; e.chk_op = 1; e.aluop = ALU_AND;
    applyStimulus(s, e);

    s = noop(); s.rst = 1'b1;
    e = ctl("reset_async", 0, 0, 0, 0, 0);
    e.chk_a = 1; e.a = 32'h0; e.chk_op = 1; e.aluop = 4'd0;
    applyStimulus(s, e);

    s = noop();
    applyStimulus(s, ctl("post_reset", 0, 0, 0, 0, 0));

    repeat (3) @(negedge clk);
    #5;
    if (expq.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
